// File: rtl/bcd_add_if.sv
// Operand/result bundle between the operand-capture logic and the serial BCD adder.
// The master drives the request and operands. The slave returns the status and the registered result.
interface bcd_add_if #(
    parameter int DIGITS = 3
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  err;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, err
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, err
    );
endinterface

// File: rtl/bcd_add_sequencer.sv
// Serial multi-digit BCD adder. It latches two packed BCD operands and rejects any digit above 9.
// It then walks one shared 4-bit digit adder with +6 correction from the least significant digit upward.
module bcd_add_sequencer #(
    parameter int DIGITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    bcd_add_if.slave    bus
);
    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_ADD   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_reg, state_next;
    logic [W-1:0]     a_reg, b_reg;
    logic             cin_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             carry_reg;
    logic             bad_reg;

    logic             busy_reg, done_reg, cout_reg, err_reg;
    logic [W-1:0]     sum_reg;

    logic [3:0]       a_dig [DIGITS];
    logic [3:0]       b_dig [DIGITS];
    logic [DIGITS-1:0] dig_bad;
    logic [W-1:0]     work;

    logic [4:0]       t_raw, t_corr;
    logic [3:0]       digit;
    logic             carry_out;
    logic             last_digit;

    assign last_digit = (idx_reg == IDX_W'(DIGITS - 1));

    // Each digit slot owns its own register, so only the slot selected by idx is written during ADD.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] slot_reg;

            assign a_dig[gi]       = a_reg[4*gi +: 4];
            assign b_dig[gi]       = b_reg[4*gi +: 4];
            assign dig_bad[gi]     = (a_dig[gi] > 4'd9) || (b_dig[gi] > 4'd9);
            assign work[4*gi +: 4] = slot_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    slot_reg <= 4'd0;
                end else if (state_reg == S_CHECK) begin
                    slot_reg <= 4'd0;
                end else if (state_reg == S_ADD && idx_reg == IDX_W'(gi)) begin
                    slot_reg <= digit;
                end
            end
        end
    endgenerate

    always_comb begin
        t_raw     = {1'b0, a_dig[idx_reg]} + {1'b0, b_dig[idx_reg]} + {4'd0, carry_reg};
        t_corr    = t_raw + 5'd6;
        digit     = t_raw[3:0];
        carry_out = 1'b0;
        if (t_raw > 5'd9) begin
            digit     = t_corr[3:0];
            carry_out = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (bus.start) state_next = S_CHECK;
            S_CHECK: state_next = (|dig_bad) ? S_DONE : S_ADD;
            S_ADD:   if (last_digit) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // busy and done follow the state by one edge. The result loads on the same edge that raises done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            cin_reg   <= 1'b0;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            bad_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_reg == S_CHECK) || (state_reg == S_ADD);
            done_reg  <= (state_reg == S_DONE);
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        a_reg   <= bus.a;
                        b_reg   <= bus.b;
                        cin_reg <= bus.cin;
                        idx_reg <= '0;
                    end
                end
                S_CHECK: begin
                    bad_reg   <= |dig_bad;
                    carry_reg <= (|dig_bad) ? 1'b0 : cin_reg;
                end
                S_ADD: begin
                    carry_reg <= carry_out;
                    if (!last_digit) idx_reg <= idx_reg + 1'b1;
                end
                S_DONE: begin
                    sum_reg  <= bad_reg ? '0 : work;
                    cout_reg <= bad_reg ? 1'b0 : carry_reg;
                    err_reg  <= bad_reg;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.sum  = sum_reg;
    assign bus.cout = cout_reg;
    assign bus.err  = err_reg;
endmodule
